// File: rtl/fetch_decode_ctrl_pkg.sv
// fetch_decode_ctrl_pkg: opcodes, instruction field positions, FSM states and
// default widths shared by the fetch/decode controller and its users.
package fetch_decode_ctrl_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int PC_W_DEF = 8;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;
  localparam int OP_LSB = 6;
  localparam int RS_LSB = 4;
  localparam int RT_LSB = 2;
  localparam int RD_LSB = 0;
  localparam int OFS_W = 6;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_e;
endpackage

// File: rtl/fetch_decode_ctrl.sv
// fetch_decode_ctrl: multi-cycle fetch/decode/execute controller driving a
// 4x8 register file; owns the PC and the halt state, all outputs registered.
module fetch_decode_ctrl
  import fetch_decode_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_data,
  output logic [1:0]        read_reg1,
  output logic [1:0]        read_reg2,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  output logic              write,
  output logic [1:0]        write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [PC_W-1:0]   pc,
  output logic              halted
);
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d, wd_q, wd_d;
  logic req_q, req_d, write_q, write_d, halted_q, halted_d;
  logic [1:0] wr_q, wr_d, rr1_q, rr1_d, rr2_q, rr2_d;
  logic [1:0] op, rs, rt, rd;
  logic [DATA_W-1:0] opnd_b;
  logic [PC_W-1:0] ofs;
  assign op = ir_q[OP_LSB +: 2];
  assign rs = ir_q[RS_LSB +: 2];
  assign rt = ir_q[RT_LSB +: 2];
  assign rd = ir_q[RD_LSB +: 2];
  assign opnd_b = (op == OP_ADDI) ? {{(DATA_W-2){ir_q[RD_LSB+1]}}, rd} : read_data2;
  assign ofs = {{(PC_W-OFS_W){ir_q[OFS_W-1]}}, ir_q[OFS_W-1:0]};
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    req_d = req_q;
    write_d = 1'b0;
    wr_d = wr_q;
    wd_d = wd_q;
    rr1_d = rr1_q;
    rr2_d = rr2_q;
    halted_d = halted_q;
    case (state_q)
      S_FETCH: begin
        if (!req_q) begin
          req_d = 1'b1;
        end else if (imem_ack) begin
          ir_d = imem_data;
          pc_d = pc_q + PC_W'(1);
          req_d = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        rr1_d = rs;
        rr2_d = rt;
        // pc already points past the jump, so the offset is relative to instr_addr+1
        pc_d = (op == OP_JMP) ? pc_q + ofs : pc_q;
        req_d = (op == OP_JMP);
        halted_d = (op == OP_HALT);
        state_d = (op == OP_JMP) ? S_FETCH : (op == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        wd_d = read_data1 + opnd_b;
        wr_d = (op == OP_ADDI) ? rt : rd;
        write_d = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        req_d = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        req_d = 1'b0;
        halted_d = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q <= RESET_PC;
      ir_q <= '0;
      req_q <= 1'b0;
      write_q <= 1'b0;
      wr_q <= '0;
      wd_q <= '0;
      rr1_q <= '0;
      rr2_q <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      req_q <= req_d;
      write_q <= write_d;
      wr_q <= wr_d;
      wd_q <= wd_d;
      rr1_q <= rr1_d;
      rr2_q <= rr2_d;
      halted_q <= halted_d;
    end
  end
  assign imem_req = req_q;
  assign imem_addr = pc_q;
  assign read_reg1 = rr1_q;
  assign read_reg2 = rr2_q;
  assign write = write_q;
  assign write_reg = wr_q;
  assign write_data = wd_q;
  assign pc = pc_q;
  assign halted = halted_q;
endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// tb_fetch_decode_ctrl: directed startup/ISA/halt checks, then random programs
// compared against an instruction-level model of PC, register file and latency.
module tb_fetch_decode_ctrl;
  logic clk = 1'b0, reset = 1'b0, ack_en = 1'b0;
  logic imem_req, write, halted;
  logic [7:0] imem_addr, imem_data, rd1, rd2, write_data, pc;
  logic [1:0] rr1, rr2, write_reg;
  logic [7:0] imem[256];
  logic [7:0] rf[4];
  logic [7:0] rf_init[4];
  logic [7:0] mrf[4];
  logic [7:0] mpc, ins;
  logic [1:0] op;
  int tests = 0, fails = 0, wr_total = 0;
  int c, wr_base, mwr, exp_lat, imm;

  fetch_decode_ctrl dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(ack_en), .imem_data(imem_data), .read_reg1(rr1), .read_reg2(rr2),
    .read_data1(rd1), .read_data2(rd2), .write(write), .write_reg(write_reg),
    .write_data(write_data), .pc(pc), .halted(halted)
  );

  assign imem_data = imem[imem_addr];
  assign rd1 = rf[rr1];
  assign rd2 = rf[rr2];
  always #5 clk = ~clk;

  // behavioural register file: reloads its initial image while reset is held
  always @(posedge clk) begin
    if (!reset) rf <= rf_init;
    else if (write) begin
      rf[write_reg] <= write_data;
      wr_total <= wr_total + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 8'hC0;
    rf_init = '{8'h05, 8'hF0, 8'h20, 8'h00};
    imem[8'h00] = 8'b00_01_10_11;
    imem[8'h01] = 8'b01_00_01_10;
    imem[8'h02] = 8'b10_001101;
    imem[8'h10] = 8'b10_111110;
    imem[8'h0F] = 8'b10_101111;
    imem[8'hFF] = 8'b00_00_00_10;
    tick(3);
    chk("rst_req", imem_req, 0);
    chk("rst_write", write, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_rr", {rr1, rr2, write_reg}, 0);
    chk("rst_wdata", write_data, 0);
    reset = 1'b1;
    tick(1);
    chk("start_req", imem_req, 1);
    chk("start_addr", imem_addr, 0);
    chk("start_flags", {halted, write}, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("wait_hold", {imem_req, imem_addr, pc}, {1'b1, 8'h00, 8'h00});
    end
    ack_en = 1'b1;
    tick(1);
    chk("fetch_pc", {imem_req, pc}, {1'b0, 8'h01});
    ack_en = 1'b0;
    tick(1);
    chk("add_rsel", {rr1, rr2}, {2'd1, 2'd2});
    chk("add_decode_nowrite", write, 0);
    ack_en = 1'b1;
    tick(1);
    chk("add_wb", {write, write_reg, write_data}, {1'b1, 2'd3, 8'h10});
    tick(1);
    chk("add_write_once", write, 0);
    chk("add_next", {imem_req, imem_addr}, {1'b1, 8'h01});
    chk("add_rf", rf[3], 8'h10);
    tick(3);
    chk("addi_wb", {write, write_reg, write_data}, {1'b1, 2'd1, 8'h03});
    tick(1);
    chk("addi_next", {write, imem_addr}, {1'b0, 8'h02});
    repeat (2) begin tick(1); chk("jmp1_nowrite", write, 0); end
    chk("jmp_fwd", {imem_req, imem_addr}, {1'b1, 8'h10});
    repeat (2) begin tick(1); chk("jmp2_nowrite", write, 0); end
    chk("jmp_back", imem_addr, 8'h0F);
    repeat (2) begin tick(1); chk("jmp3_nowrite", write, 0); end
    chk("jmp_to_ff", imem_addr, 8'hFF);
    tick(1);
    chk("pc_wrap", pc, 8'h00);
    tick(2);
    chk("wrap_add_wb", {write, write_reg, write_data}, {1'b1, 2'd2, 8'h0A});
    tick(1);
    chk("wrap_next", {imem_req, imem_addr}, {1'b1, 8'h00});
    tick(3);
    chk("midwb_write", write, 1);
    reset = 1'b0;
    #1;
    chk("midwb_rst_write", write, 0);
    chk("midwb_rst_pc", pc, 0);
    imem[8'h00] = 8'hC0;
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("halt_fetch", {imem_req, imem_addr}, {1'b1, 8'h00});
    tick(2);
    chk("halt_set", halted, 1);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("halt_idle", {imem_req, write, halted}, 3'b001);
    end
    reset = 1'b0;
    tick(1);
    chk("halt_rst", halted, 0);
    reset = 1'b1;
    tick(1);
    chk("halt_resume", {imem_req, imem_addr, halted}, {1'b1, 8'h00, 1'b0});

    reset = 1'b0;
    ack_en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      op = 2'($urandom_range(0, 2));
      imem[i] = {op, 6'($urandom)};
    end
    for (int i = 0; i < 4; i++) rf_init[i] = 8'($urandom);
    tick(2);
    mrf = rf_init;
    mpc = 8'h00;
    mwr = 0;
    wr_base = wr_total;
    reset = 1'b1;
    for (int k = 0; k < 200; k++) begin
      ack_en = 1'b0;
      c = 0;
      while (imem_req !== 1'b1 && c < 50) begin tick(1); c++; end
      chk("rnd_req_timeout", c < 50, 1);
      if (c >= 50) break;
      chk("rnd_pc", imem_addr, mpc);
      chk("rnd_rf", {rf[0], rf[1], rf[2], rf[3]}, {mrf[0], mrf[1], mrf[2], mrf[3]});
      chk("rnd_writes", wr_total - wr_base, mwr);
      tick($urandom_range(0, 2));
      ack_en = 1'b1;
      tick(1);
      chk("rnd_fetch", {imem_req, pc}, {1'b0, 8'(mpc + 8'd1)});
      ins = imem[mpc];
      mpc = mpc + 8'd1;
      if (ins[7:6] == 2'b10) begin
        mpc = 8'(int'(mpc) + int'(ins[5:0]) - (ins[5] ? 64 : 0));
        exp_lat = 1;
      end else begin
        imm = int'(ins[1:0]) - (ins[1] ? 4 : 0);
        if (ins[7:6] == 2'b00) mrf[ins[1:0]] = mrf[ins[5:4]] + mrf[ins[3:2]];
        else mrf[ins[3:2]] = 8'(int'(mrf[ins[5:4]]) + imm);
        mwr++;
        exp_lat = 3;
      end
      c = 0;
      do begin
        ack_en = 1'($urandom);
        tick(1);
        c++;
      end while (!imem_req && c < 50);
      chk("rnd_latency", c, exp_lat);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
